// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core. One shared instruction/data memory port with a
// req/ready handshake. Every instruction walks FETCH/DECODE/EXEC[/MEM][/WB];
// the memory request and retire/flag outputs are decoded from the state
// register and registered datapath values, gated off while rst is high.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic [31:0]       retire_pc,
    output logic              illegal,
    output logic              misaligned
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ipc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_t;
    logic [31:0] r_res;
    logic [31:0] r_mdr;
    logic [4:0]  r_dest;
    logic [31:0] r_rf [32];

    // Instruction fields, all taken from the latched instruction register.
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_btarget;
    logic [31:0] w_jtarget;
    logic [31:0] w_mem_sum;
    logic        w_misal;
    logic        w_is_lw;
    logic        w_is_sw;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_addr_full;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zext    = {16'h0000, r_ir[15:0]};
    // r_pc already points at the following instruction when these are used.
    assign w_btarget = r_pc + {w_sext[29:0], 2'b00};
    assign w_jtarget = {r_pc[31:28], r_ir[25:0], 2'b00};
    assign w_mem_sum = r_a + w_sext;
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    // r0 is never written, but the read is forced to zero regardless.
    assign w_rs_val  = (w_rs == 5'd0) ? 32'h0000_0000 : r_rf[w_rs];
    assign w_rt_val  = (w_rt == 5'd0) ? 32'h0000_0000 : r_rf[w_rt];

    logic [31:0] w_res;
    logic [4:0]  w_dest;
    logic        w_to_wb;
    logic        w_is_mem;
    logic        w_take;
    logic        w_is_jump;
    logic        w_is_jal;
    logic        w_ill;
    logic        w_exec_retire;

    // EXEC decode: ALU result, destination and next-step classification.
    always_comb begin
        w_res     = 32'h0000_0000;
        w_dest    = 5'd0;
        w_to_wb   = 1'b0;
        w_is_mem  = 1'b0;
        w_take    = 1'b0;
        w_is_jump = 1'b0;
        w_is_jal  = 1'b0;
        w_ill     = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_dest  = w_rd;
                w_to_wb = 1'b1;
                case (w_funct)
                    FN_ADDU: w_res = r_a + r_b;
                    FN_SUBU: w_res = r_a - r_b;
                    FN_AND:  w_res = r_a & r_b;
                    FN_OR:   w_res = r_a | r_b;
                    FN_SLT:  w_res = ($signed(r_a) < $signed(r_b)) ? 32'h0000_0001 : 32'h0000_0000;
                    default: begin
                        w_to_wb = 1'b0;
                        w_ill   = 1'b1;
                    end
                endcase
            end
            OP_ADDIU: begin
                w_res   = r_a + w_sext;
                w_dest  = w_rt;
                w_to_wb = 1'b1;
            end
            OP_ORI: begin
                w_res   = r_a | w_zext;
                w_dest  = w_rt;
                w_to_wb = 1'b1;
            end
            OP_LUI: begin
                w_res   = {r_ir[15:0], 16'h0000};
                w_dest  = w_rt;
                w_to_wb = 1'b1;
            end
            OP_LW, OP_SW: begin
                w_res    = w_mem_sum;
                w_dest   = w_rt;
                w_is_mem = 1'b1;
            end
            OP_BEQ:  w_take = (r_a == r_b);
            OP_BNE:  w_take = (r_a != r_b);
            OP_J:    w_is_jump = 1'b1;
            OP_JAL: begin
                w_is_jump = 1'b1;
                w_is_jal  = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign w_misal       = w_is_mem && (w_mem_sum[1:0] != 2'b00);
    // Everything that neither writes back nor reaches memory finishes in EXEC.
    assign w_exec_retire = !(w_to_wb || (w_is_mem && !w_misal));
    assign w_addr_full   = (r_state == S_MEM) ? r_res : r_pc;

    assign mem_req    = !rst && ((r_state == S_FETCH) || (r_state == S_MEM));
    assign mem_we     = !rst && (r_state == S_MEM) && w_is_sw;
    assign mem_addr   = rst ? {ADDR_W{1'b0}} : w_addr_full[ADDR_W-1:0];
    assign mem_wdata  = r_b;
    assign mem_be     = 4'hF;
    assign retire     = !rst && (((r_state == S_EXEC) && w_exec_retire) ||
                                 ((r_state == S_MEM) && w_is_sw && mem_ready) ||
                                 (r_state == S_WB));
    assign retire_pc  = r_ipc;
    assign illegal    = !rst && (r_state == S_EXEC) && w_ill;
    assign misaligned = !rst && (r_state == S_EXEC) && w_misal;

    // Control FSM together with the datapath registers and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ipc   <= 32'h0000_0000;
            r_ir    <= 32'h0000_0000;
            r_a     <= 32'h0000_0000;
            r_b     <= 32'h0000_0000;
            r_t     <= 32'h0000_0000;
            r_res   <= 32'h0000_0000;
            r_mdr   <= 32'h0000_0000;
            r_dest  <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0000_0000;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_ipc   <= r_pc;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= w_rs_val;
                    r_b     <= w_rt_val;
                    r_t     <= w_btarget;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res  <= w_res;
                    r_dest <= w_dest;
                    if (w_take) begin
                        r_pc <= r_t;
                    end else if (w_is_jump) begin
                        r_pc <= w_jtarget;
                    end
                    if (w_is_jal) begin
                        r_rf[31] <= r_pc;
                    end
                    if (w_to_wb) begin
                        r_state <= S_WB;
                    end else if (w_is_mem && !w_misal) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_sw) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (r_dest != 5'd0) begin
                        r_rf[r_dest] <= w_is_lw ? r_mdr : r_res;
                    end
                    r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule
